image_frame_buffer: RTL and testbench
=====================================

IMAGE_FRAME_BUFFER -- requirements
Module: image_frame_buffer

Interface
REQ-001 The block SHALL be parametrised as follows, one per line: name, default, meaning.
- H_RES, 160, pixels per line.
- V_RES, 120, lines per frame.
- X_BITS, 8, x coordinate width.
- Y_BITS, 7, y coordinate width.
- COLOR_BITS, 3, bits per pixel.
- WQ_DEPTH, 4, write-queue entries (power of 2).

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state changes on the rising edge.
- reset, in, 1, synchronous active-high reset.
- rd_en, in, 1, read request.
- x_read, in, X_BITS, read x coordinate.
- y_read, in, Y_BITS, read y coordinate.
- color_out, out, COLOR_BITS, read data.
- rd_valid, out, 1, color_out valid this cycle.
- wren, in, 1, write request.
- x_write, in, X_BITS, write x coordinate.
- y_write, in, Y_BITS, write y coordinate.
- color_in, in, COLOR_BITS, write data.
- wr_full, out, 1, write queue cannot accept.
- wr_overflow, out, 1, sticky flag: write dropped.
- fill_start, in, 1, start full-frame fill.
- fill_color, in, COLOR_BITS, fill value.
- fill_busy, out, 1, fill in progress.
- fill_done, out, 1, one-cycle pulse at fill end.

Function
REQ-004 Storage SHALL be a single-port array of H_RES*V_RES words, each COLOR_BITS wide, performing one access per cycle; the address SHALL be y*H_RES+x.
REQ-005 A coordinate SHALL be out of range when x>=H_RES or y>=V_RES.
REQ-006 Memory port priority per cycle SHALL be: fill engine, then accepted read, then write-queue drain.
REQ-007 Read: rd_en high with fill_busy low SHALL be accepted; rd_valid SHALL be high exactly 1 cycle later, with color_out holding that pixel.
REQ-008 An out-of-range accepted read SHALL give rd_valid=1 with color_out=0 one cycle later, and SHALL make no memory access.
REQ-009 rd_en while fill_busy=1 SHALL be ignored and no rd_valid SHALL result.
REQ-010 rd_valid SHALL be a single-cycle pulse per accepted read; color_out SHALL hold its last value between reads.
REQ-011 Write: wren with wr_full=0 and an in-range coordinate SHALL push {address, color_in} into a FIFO of WQ_DEPTH entries.
REQ-012 Out-of-range writes SHALL be discarded silently and SHALL NOT set wr_overflow.
REQ-013 wr_full SHALL be high when count==WQ_DEPTH or fill_busy=1.
REQ-014 wren with wr_full=1 SHALL be dropped and SHALL set wr_overflow; wr_overflow SHALL clear only on reset.
REQ-015 The FIFO head SHALL be written to memory in any cycle with no fill access and no accepted read.
REQ-016 A push and a drain in the same cycle SHALL leave count unchanged.
REQ-017 A push while wr_full=1 SHALL be rejected even if a drain occurs that cycle.
REQ-018 Writes SHALL retire in FIFO order.
REQ-019 There SHALL be no read forwarding: a read of an address still queued SHALL return the prior memory contents.
REQ-020 The fill FSM SHALL have states IDLE, FILL and DONE.
REQ-021 IDLE->FILL SHALL occur on fill_start; fill_color SHALL be latched and all FIFO entries discarded on this transition.
REQ-022 FILL SHALL write the latched color to addresses 0..H_RES*V_RES-1, one per cycle, taking H_RES*V_RES cycles.
REQ-023 FILL->DONE SHALL occur after the last address; DONE SHALL assert fill_done for 1 cycle, then return to IDLE.
REQ-024 fill_busy SHALL be high in FILL and DONE.
REQ-025 fill_start in FILL or DONE SHALL be ignored.
REQ-026 wren during FILL or DONE SHALL be dropped and SHALL set wr_overflow.
REQ-027 A read accepted in the cycle fill_start is taken SHALL still complete (the read wins that cycle); the fill SHALL begin on the next cycle.

Reset
REQ-028 Reset SHALL set rd_valid=0, color_out=0, wr_full=0, wr_overflow=0, fill_busy=0 and fill_done=0, empty the FIFO, and put the FSM in IDLE.
REQ-029 Reset SHALL NOT alter memory contents; reset mid-fill SHALL abort the fill and leave the frame partially filled, and queued writes SHALL be lost.

Verification (defaults)
REQ-030 Write (5,2)=3'b101, idle 2 cycles, read (5,2) -> rd_valid=1 one cycle later, color_out=3'b101; address 325 was written.
REQ-031 wren held 6 cycles with rd_en held high (no drain) -> wr_full=1 after 4 pushes; pushes 5-6 are dropped; wr_overflow=1.
REQ-032 Read (160,0) -> rd_valid=1, color_out=0; write (0,120) -> queue count unchanged, wr_overflow=0.
REQ-033 fill_start with fill_color=3'b010 -> fill_busy=1 for 19201 cycles, fill_done pulses in the last of them; reads of (0,0) and (159,119) then return 3'b010.
REQ-034 Reset asserted 100 cycles into a fill -> fill_busy=0 next cycle; (0,0)=fill color, (159,119) unchanged.
REQ-035 Queue a write to (1,1), then immediately read (1,1) -> old value; reading again after the drain returns the new value.

Source files
------------

// File: rtl/image_frame_buffer.sv
// Single-port frame buffer with a small write queue and a full-frame fill engine.
// One memory access per cycle, arbitrated fill > read > queued write.
module image_frame_buffer #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3,
  parameter int WQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [X_BITS-1:0]     x_read,
  input  logic [Y_BITS-1:0]     y_read,
  output logic [COLOR_BITS-1:0] color_out,
  output logic                  rd_valid,
  input  logic                  wren,
  input  logic [X_BITS-1:0]     x_write,
  input  logic [Y_BITS-1:0]     y_write,
  input  logic [COLOR_BITS-1:0] color_in,
  output logic                  wr_full,
  output logic                  wr_overflow,
  input  logic                  fill_start,
  input  logic [COLOR_BITS-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done
);

  localparam int NPIX = H_RES * V_RES;
  localparam int AW   = $clog2(NPIX);
  localparam int PW   = $clog2(WQ_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  fill_state_t state, state_next;

  logic [COLOR_BITS-1:0] mem [NPIX];
  logic [COLOR_BITS-1:0] mem_rdata;
  logic [COLOR_BITS-1:0] last_color;
  logic [COLOR_BITS-1:0] fill_color_q;
  logic [AW-1:0]         fill_addr;
  logic                  rd_oor;

  logic [AW-1:0]         q_addr  [WQ_DEPTH];
  logic [COLOR_BITS-1:0] q_color [WQ_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_in_range, wr_in_range;
  logic          rd_accept, fill_access, fill_begin, push, drain;

  always_comb begin
    rd_in_range = (int'(x_read) < H_RES) && (int'(y_read) < V_RES);
    wr_in_range = (int'(x_write) < H_RES) && (int'(y_write) < V_RES);
    rd_addr     = AW'(y_read) * AW'(H_RES) + AW'(x_read);
    wr_addr     = AW'(y_write) * AW'(H_RES) + AW'(x_write);
  end

  always_comb begin
    fill_busy   = (state != IDLE);
    fill_done   = (state == DONE);
    fill_access = (state == FILL);
    fill_begin  = (state == IDLE) && fill_start;
    wr_full     = (count == CW'(WQ_DEPTH)) || fill_busy;
    rd_accept   = rd_en && !fill_busy;
    push        = wren && !wr_full && wr_in_range;
    drain       = (count != '0) && !fill_access && !rd_accept;
  end

  // Fill FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fill_start) state_next = FILL;
      FILL:    if (fill_addr == AW'(NPIX - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_addr    <= '0;
      fill_color_q <= '0;
    end else begin
      if (fill_begin) fill_color_q <= fill_color;
      if (state == FILL) fill_addr <= fill_addr + 1'b1;
      else               fill_addr <= '0;
    end
  end

  // Single memory port; nothing is written while reset is held so queued data is simply lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_access)
        mem[fill_addr] <= fill_color_q;
      else if (rd_accept) begin
        if (rd_in_range) mem_rdata <= mem[rd_addr];
      end else if (drain)
        mem[q_addr[rd_ptr]] <= q_color[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fill_begin) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_addr[wr_ptr]  <= wr_addr;
        q_color[wr_ptr] <= color_in;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wr_overflow <= 1'b0;
    else if (wren && wr_full) wr_overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      rd_oor     <= 1'b0;
      last_color <= '0;
    end else begin
      rd_valid   <= rd_accept;
      if (rd_accept) rd_oor <= !rd_in_range;
      last_color <= color_out;
    end
  end

  // Read data is muxed out of the RAM register; last_color holds it between reads.
  always_comb begin
    color_out = last_color;
    if (rd_valid) color_out = rd_oor ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_image_frame_buffer.sv
// Directed plus randomized checks of image_frame_buffer against a queue/array
// reference model of the frame buffer and its pending writes.
module tb_image_frame_buffer;

  localparam int H = 160;
  localparam int V = 120;
  localparam int N = H * V;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] x_read = '0;
  logic [6:0] y_read = '0;
  logic [2:0] color_out;
  logic       rd_valid;
  logic       wren = 1'b0;
  logic [7:0] x_write = '0;
  logic [6:0] y_write = '0;
  logic [2:0] color_in = '0;
  logic       wr_full;
  logic       wr_overflow;
  logic       fill_start = 1'b0;
  logic [2:0] fill_color = '0;
  logic       fill_busy;
  logic       fill_done;

  always #5 clk = ~clk;

  image_frame_buffer #(
    .H_RES(H), .V_RES(V), .X_BITS(8), .Y_BITS(7), .COLOR_BITS(3), .WQ_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .x_read(x_read), .y_read(y_read),
    .color_out(color_out), .rd_valid(rd_valid),
    .wren(wren), .x_write(x_write), .y_write(y_write), .color_in(color_in),
    .wr_full(wr_full), .wr_overflow(wr_overflow),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { int addr; logic [2:0] c; } wr_t;
  logic [2:0] ref_mem [N];
  wr_t        q [$];
  logic       m_valid = 1'b0;
  logic [2:0] m_color = '0;
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    m_valid = 1'b0;
    m_color = '0;
    m_ovf   = 1'b0;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_color_out", color_out, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_wr_overflow", wr_overflow, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
  endtask

  // One idle-frame cycle: model the read, the queue drain and the push, then compare.
  task automatic cyc(input logic r, input int rx, input int ry,
                     input logic w, input int wx, input int wy, input logic [2:0] wc);
    bit  full, rin, win;
    wr_t e;
    full = (q.size() == 4);
    rin  = (rx < H) && (ry < V);
    win  = (wx < H) && (wy < V);
    rd_en = r; x_read = rx[7:0]; y_read = ry[6:0];
    wren = w; x_write = wx[7:0]; y_write = wy[6:0]; color_in = wc;
    m_valid = r;
    if (r) m_color = rin ? ref_mem[ry * H + rx] : 3'd0;
    if (!r && q.size() > 0) begin
      e = q.pop_front();
      ref_mem[e.addr] = e.c;
    end
    if (w && full) m_ovf = 1'b1;
    else if (w && win) begin
      e.addr = wy * H + wx;
      e.c    = wc;
      q.push_back(e);
    end
    tick();
    rd_en = 1'b0;
    wren  = 1'b0;
    chk("rd_valid", rd_valid, m_valid);
    chk("color_out", color_out, m_color);
    chk("wr_full", wr_full, (q.size() == 4));
    chk("wr_overflow", wr_overflow, m_ovf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dones, done_at, rv_bad;
    logic [2:0] exp_last;

    do_reset();

    // Full-frame fill with 3'b010; mid-fill fill_start, rd_en and wren must be ignored/dropped.
    fill_color = 3'b010;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("fill_busy_after_start", fill_busy, 1);
    n = 0; dones = 0; done_at = 0; rv_bad = 0;
    rd_en = 1'b1; x_read = 8'd0; y_read = 7'd0;
    while (fill_busy && n < 20000) begin
      n++;
      if (fill_done) begin dones++; done_at = n; end
      if (rd_valid) rv_bad++;
      fill_start = (n == 50);
      fill_color = (n == 50) ? 3'b101 : 3'b010;
      wren = (n == 60); x_write = 8'd3; y_write = 7'd3; color_in = 3'b111;
      tick();
    end
    rd_en = 1'b0; wren = 1'b0; fill_start = 1'b0;
    chk("fill_busy_cycles", n, 19201);
    chk("fill_done_pulses", dones, 1);
    chk("fill_done_position", done_at, 19201);
    chk("rd_valid_during_fill", rv_bad, 0);
    chk("rd_valid_after_fill", rd_valid, 0);
    chk("overflow_wren_in_fill", wr_overflow, 1);
    for (int i = 0; i < N; i++) ref_mem[i] = 3'b010;
    m_ovf = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("fill_px_0_0", color_out, 3'b010);
    cyc(1, 159, 119, 0, 0, 0, 0);
    chk("fill_px_159_119", color_out, 3'b010);

    do_reset();

    // Write then read back after two idle cycles.
    cyc(0, 0, 0, 1, 5, 2, 3'b101);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 2, 0, 0, 0, 0);
    chk("px_5_2_written", color_out, 3'b101);

    // No forwarding: a queued write is invisible until drained.
    cyc(0, 0, 0, 1, 1, 1, 3'b110);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("px_1_1_old", color_out, 3'b010);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("px_1_1_new", color_out, 3'b110);

    // Out-of-range read and write.
    cyc(1, 160, 0, 0, 0, 0, 0);
    chk("oor_read_valid", rd_valid, 1);
    chk("oor_read_zero", color_out, 0);
    cyc(0, 0, 0, 1, 0, 120, 3'b111);
    chk("oor_write_no_ovf", wr_overflow, 0);

    // Queue fills while reads block draining; pushes 5 and 6 are dropped.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 1, 10 + i, 0, 3'(i));
      chk("wq_full_step", wr_full, (i >= 3));
    end
    chk("wq_overflow_set", wr_overflow, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 10 + i, 0, 0, 0, 0, 0);
      chk("wq_retired", color_out, (i < 4) ? i : 2);
    end

    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) == 0), $urandom_range(0, 170), $urandom_range(0, 125),
          ($urandom_range(0, 1) == 0), $urandom_range(0, 170), $urandom_range(0, 125),
          3'($urandom));
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0);

    // Read taken in the fill_start cycle completes; reset 100 cycles in aborts the fill.
    exp_last = ref_mem[N - 1];
    fill_color = 3'b110;
    fill_start = 1'b1;
    rd_en = 1'b1; x_read = 8'd159; y_read = 7'd119;
    tick();
    fill_start = 1'b0;
    rd_en = 1'b0;
    chk("read_at_fill_start_valid", rd_valid, 1);
    chk("read_at_fill_start_data", color_out, exp_last);
    chk("fill_busy_started", fill_busy, 1);
    repeat (99) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_fill_busy", fill_busy, 0);
    chk("abort_fill_done", fill_done, 0);
    q.delete();
    m_valid = 1'b0; m_color = '0; m_ovf = 1'b0;
    ref_mem[0] = 3'b110;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("abort_px_0_0", color_out, 3'b110);
    cyc(1, 159, 119, 0, 0, 0, 0);
    chk("abort_px_last", color_out, exp_last);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
